// File: rtl/stream_pkg.sv
// Shared encodings and sizing helper for the stream header codec.
package stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INSERT = 2'd1,
    MODE_STRIP  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_HDR   = 2'd1,
    S_STRIP = 2'd2,
    S_BODY  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/stream_header_codec.sv
// AXI-Stream header codec: inserts, strips or passes HDR_BEATS leading beats
// per packet, with a single registered output stage.
module stream_header_codec
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HDR_BEATS  = 2,
  parameter int ID_WIDTH   = DATA_WIDTH * HDR_BEATS
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            mode,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tlast,
  input  logic [ID_WIDTH-1:0]   in_tid,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tlast,
  output logic [ID_WIDTH-1:0]   out_tid,
  output logic                  err_runt
);

  localparam int CNT_W = clog2(HDR_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HDR_BEATS - 1);

  state_t              r_state, w_next_state;
  mode_t               r_cur_mode, w_mode_dec;
  logic [CNT_W-1:0]    r_hdr_cnt;
  logic [ID_WIDTH-1:0] r_tid, r_hdr_asm, w_hdr_next;
  logic                w_slot_free;
  logic                w_start_take, w_load_hdr, w_load_body, w_strip_acc, w_runt;

  assign w_slot_free = !out_tvalid || out_tready;

  // Encoding 3 is folded into pass so cur_mode only ever holds legal values.
  always_comb begin
    w_mode_dec = MODE_PASS;
    case (mode)
      2'd1:    w_mode_dec = MODE_INSERT;
      2'd2:    w_mode_dec = MODE_STRIP;
      default: w_mode_dec = MODE_PASS;
    endcase
  end

  always_comb begin
    w_hdr_next = r_hdr_asm;
    w_hdr_next[DATA_WIDTH*int'(r_hdr_cnt) +: DATA_WIDTH] = in_tdata;
  end

  always_comb begin
    w_next_state = r_state;
    in_tready    = 1'b0;
    w_start_take = 1'b0;
    w_load_hdr   = 1'b0;
    w_load_body  = 1'b0;
    w_strip_acc  = 1'b0;
    w_runt       = 1'b0;
    case (r_state)
      S_START: begin
        if (in_tvalid) begin
          w_start_take = 1'b1;
          case (w_mode_dec)
            MODE_INSERT: w_next_state = S_HDR;
            MODE_STRIP:  w_next_state = S_STRIP;
            default:     w_next_state = S_BODY;
          endcase
        end
      end
      S_HDR: begin
        if (w_slot_free) begin
          w_load_hdr = 1'b1;
          if (r_hdr_cnt == LAST_CNT) w_next_state = S_BODY;
        end
      end
      S_STRIP: begin
        // Header beats never reach the output, so they are accepted regardless of it.
        in_tready = 1'b1;
        if (in_tvalid) begin
          w_strip_acc = 1'b1;
          if (in_tlast) begin
            w_runt       = 1'b1;
            w_next_state = S_START;
          end else if (r_hdr_cnt == LAST_CNT) begin
            w_next_state = S_BODY;
          end
        end
      end
      S_BODY: begin
        in_tready = w_slot_free;
        if (in_tvalid && w_slot_free) begin
          w_load_body = 1'b1;
          if (in_tlast) w_next_state = S_START;
        end
      end
      default: w_next_state = S_START;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_START;
      r_hdr_cnt  <= '0;
      r_cur_mode <= MODE_PASS;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
      err_runt   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      err_runt <= w_runt;

      if (w_start_take) begin
        r_cur_mode <= w_mode_dec;
        r_hdr_cnt  <= '0;
      end else if (w_load_hdr || w_strip_acc) begin
        r_hdr_cnt <= r_hdr_cnt + CNT_W'(1);
      end

      if (w_load_hdr) begin
        out_tvalid <= 1'b1;
        out_tdata  <= r_tid[DATA_WIDTH*int'(r_hdr_cnt) +: DATA_WIDTH];
        out_tlast  <= 1'b0;
      end else if (w_load_body) begin
        out_tvalid <= 1'b1;
        out_tdata  <= in_tdata;
        out_tlast  <= in_tlast;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end

      // A stripped header stays visible until a non-strip packet begins.
      if (w_strip_acc && !in_tlast && (r_hdr_cnt == LAST_CNT)) begin
        out_tid <= w_hdr_next;
      end else if ((r_state == S_START) &&
                   ((r_cur_mode != MODE_STRIP) || (in_tvalid && (w_mode_dec != MODE_STRIP)))) begin
        out_tid <= '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_start_take && (w_mode_dec == MODE_INSERT)) r_tid <= in_tid;
    if (w_strip_acc) r_hdr_asm <= w_hdr_next;
  end

endmodule

// File: tb/tb_stream_header_codec.sv
// Directed bench for stream_header_codec: vector table plus reset and HDR_BEATS=3 sequences.
module tb_stream_header_codec;

  logic        clk = 1'b0;
  logic        areset;
  logic [1:0]  mode;
  logic        in_tvalid, in_tready, in_tlast;
  logic [7:0]  in_tdata;
  logic [15:0] in_tid;
  logic        out_tvalid, out_tready, out_tlast, err_runt;
  logic [7:0]  out_tdata;
  logic [15:0] out_tid;

  logic [1:0]  m3_mode;
  logic        m3_in_tvalid, m3_in_tready, m3_in_tlast;
  logic [7:0]  m3_in_tdata;
  logic [23:0] m3_in_tid;
  logic        m3_out_tvalid, m3_out_tready, m3_out_tlast, m3_err_runt;
  logic [7:0]  m3_out_tdata;
  logic [23:0] m3_out_tid;

  always #5 clk = ~clk;

  stream_header_codec #(.DATA_WIDTH(8), .HDR_BEATS(2)) u_dut (
    .aclk(clk), .areset(areset), .mode(mode),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tlast(in_tlast), .in_tid(in_tid),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast), .out_tid(out_tid), .err_runt(err_runt)
  );

  stream_header_codec #(.DATA_WIDTH(8), .HDR_BEATS(3)) u_dut3 (
    .aclk(clk), .areset(areset), .mode(m3_mode),
    .in_tvalid(m3_in_tvalid), .in_tready(m3_in_tready), .in_tdata(m3_in_tdata),
    .in_tlast(m3_in_tlast), .in_tid(m3_in_tid),
    .out_tvalid(m3_out_tvalid), .out_tready(m3_out_tready), .out_tdata(m3_out_tdata),
    .out_tlast(m3_out_tlast), .out_tid(m3_out_tid), .err_runt(m3_err_runt)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  mode_mid;
    logic [15:0] tid;
    int          n;
    logic [63:0] d;
    bit          rnd;
    int          exp_wait;
    int          n_out;
    logic [63:0] od;
    logic [15:0] otid;
  } vec_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [15:0] tid;
  } beat_t;

  vec_t  vecs [7];
  beat_t exp_q [$];
  logic [8:0] q3 [$];
  int n_chk = 0, n_pass = 0, runt_cnt = 0;
  bit mon_en = 1'b0, rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] mm, input logic [15:0] tid,
                              input int n, input logic [63:0] d, input bit rnd, input int w,
                              input int no, input logic [63:0] od, input logic [15:0] otid);
    vec_t v;
    v.mode = m; v.mode_mid = mm; v.tid = tid; v.n = n; v.d = d; v.rnd = rnd;
    v.exp_wait = w; v.n_out = no; v.od = od; v.otid = otid;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: every output handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (err_runt) runt_cnt++;
    if (mon_en && out_tvalid && out_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {7'd0, out_tdata, out_tlast, out_tid}, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("out_beat", {7'd0, out_tdata, out_tlast, out_tid}, {7'd0, b.d, b.l, b.tid});
      end
    end
    if (m3_out_tvalid && m3_out_tready) q3.push_back({m3_out_tdata, m3_out_tlast});
  end

  task automatic send_vec(input int k);
    vec_t  v;
    beat_t b;
    int    waits, cyc;
    bit    hs;
    v = vecs[k];
    waits = 0;
    rnd_rdy = v.rnd;
    for (int j = 0; j < v.n_out; j++) begin
      b.d = v.od[8*j +: 8]; b.l = (j == v.n_out - 1); b.tid = v.otid;
      exp_q.push_back(b);
    end
    for (int i = 0; i < v.n; i++) begin
      in_tvalid = 1'b1; in_tdata = v.d[8*i +: 8]; in_tlast = (i == v.n - 1); in_tid = v.tid;
      if (i == 0) mode = v.mode;
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 200) begin
        @(negedge clk);
        hs = in_tready;
        if (!hs && i == 0) waits++;
        @(posedge clk); #1;
        cyc++;
      end
      if (!hs) chk($sformatf("handshake_timeout_v%0d", k), 32'd0, 32'd1);
      if (i == 0) begin
        mode = v.mode_mid;
        if (v.exp_wait >= 0) chk($sformatf("ready_delay_v%0d", k), waits, v.exp_wait);
      end
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    rnd_rdy = 1'b0;
    cyc = 0;
    while ((exp_q.size() != 0 || out_tvalid) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = mk(2'd1, 2'd1, 16'hBEEF, 3, 64'h030201, 1'b0, 3, 5, 64'h030201BEEF, 16'h0000);
    vecs[1] = mk(2'd2, 2'd2, 16'h0000, 4, 64'h201055AA, 1'b0, 1, 2, 64'h2010, 16'h55AA);
    vecs[2] = mk(2'd2, 2'd2, 16'h0000, 2, 64'h55AA, 1'b0, 1, 0, 64'h0, 16'h0000);
    vecs[3] = mk(2'd2, 2'd2, 16'h0000, 4, 64'h04030201, 1'b0, 1, 2, 64'h0403, 16'h0201);
    vecs[4] = mk(2'd0, 2'd1, 16'hFFFF, 4, 64'h44332211, 1'b1, -1, 4, 64'h44332211, 16'h0000);
    vecs[5] = mk(2'd1, 2'd1, 16'hC0DE, 4, 64'h88776655, 1'b1, -1, 6, 64'h88776655C0DE, 16'h0000);
    vecs[6] = mk(2'd1, 2'd1, 16'h1234, 1, 64'h9A, 1'b0, 3, 3, 64'h9A1234, 16'h0000);

    areset = 1'b1; mode = 2'd0; in_tvalid = 1'b0; in_tdata = 8'h00; in_tlast = 1'b0; in_tid = '0;
    m3_mode = 2'd0; m3_in_tvalid = 1'b0; m3_in_tdata = 8'h00; m3_in_tlast = 1'b0; m3_in_tid = '0;
    m3_out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_out_tid", out_tid, 0);
    chk("rst_err_runt", err_runt, 0);
    chk("rst_in_tready", in_tready, 0);
    @(negedge clk) areset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) send_vec(k);
    drain("drain_main");
    chk("runt_pulses", runt_cnt, 1);

    // Reset in the middle of an inserted header.
    mon_en = 1'b0;
    mode = 2'd1; in_tid = 16'hBEEF; in_tdata = 8'h01; in_tlast = 1'b0; in_tvalid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hdr0_before_reset", {out_tvalid, out_tdata}, {1'b1, 8'hEF});
    #1 areset = 1'b1;
    #1;
    chk("async_rst_tvalid", out_tvalid, 0);
    chk("async_rst_tdata", out_tdata, 0);
    in_tvalid = 1'b0;
    @(negedge clk) areset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_vec(6);
    drain("drain_after_reset");
    chk("runt_pulses_final", runt_cnt, 1);

    // One-beat insert with a three-beat header.
    begin
      int cyc, waits;
      bit hs;
      m3_mode = 2'd1; m3_in_tid = 24'h030201; m3_in_tdata = 8'h77; m3_in_tlast = 1'b1;
      m3_in_tvalid = 1'b1;
      cyc = 0; waits = 0; hs = 1'b0;
      while (!hs && cyc < 50) begin
        @(negedge clk);
        hs = m3_in_tready;
        if (!hs) waits++;
        @(posedge clk); #1;
        cyc++;
      end
      m3_in_tvalid = 1'b0; m3_in_tlast = 1'b0;
      chk("h3_ready_delay", waits, 4);
      cyc = 0;
      while (q3.size() < 4 && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("h3_beat_count", q3.size(), 4);
      if (q3.size() >= 4) begin
        chk("h3_beat0", q3[0], {8'h01, 1'b0});
        chk("h3_beat1", q3[1], {8'h02, 1'b0});
        chk("h3_beat2", q3[2], {8'h03, 1'b0});
        chk("h3_beat3", q3[3], {8'h77, 1'b1});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_header_codec.md
Name: stream_header_codec

Overview:
- Parametrised successor to the single-beat stream labeler on the AXI-Stream datapath between sector buffers and the host/drive interfaces.
- Insert mode: prepends HDR_BEATS header beats, taken from in_tid, to every packet.
- Strip mode: removes HDR_BEATS leading beats from every packet and presents them on out_tid for the rest of that packet.
- Pass mode: forwards packets unchanged. Mode is sampled only at packet boundaries.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- HDR_BEATS, 2, header length in beats; legal range 1..15.
- ID_WIDTH, DATA_WIDTH*HDR_BEATS, width of in_tid and out_tid.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- mode  in  2  0=pass, 1=insert, 2=strip; 3 is treated as pass.
- in_tvalid  in  1  upstream valid.
- in_tready  out  1  upstream ready.
- in_tdata  in  DATA_WIDTH  upstream data.
- in_tlast  in  1  upstream end of packet.
- in_tid  in  ID_WIDTH  header value for insert mode; beat 0 is bits [DATA_WIDTH-1:0].
- out_tvalid  out  1  downstream valid (registered).
- out_tready  in  1  downstream ready.
- out_tdata  out  DATA_WIDTH  downstream data (registered).
- out_tlast  out  1  downstream end of packet (registered).
- out_tid  out  ID_WIDTH  in strip mode, the reassembled header; 0 in other modes.
- err_runt  out  1  one-cycle pulse when a strip-mode packet ends at or before its last header beat.

Behaviour:
- Reset is asynchronous and active-high on areset. On reset:
  - out_tvalid, out_tdata, out_tlast, out_tid, err_runt = 0.
  - state = S_START, hdr_cnt = 0, cur_mode = pass.
- Output register: "slot free" = !out_tvalid || out_tready. out_tvalid clears on out_tready unless a new beat loads in the same cycle. There is no combinational path from in_* to out_*.
- S_START (packet boundary):
  - in_tready = 0.
  - When in_tvalid=1: latch cur_mode <= mode and clear hdr_cnt.
  - Insert mode: also latch tid_reg <= in_tid, then go to S_HDR.
  - Strip mode: go to S_STRIP. Pass mode: go to S_BODY.
  - Costs one idle cycle per packet.
- S_HDR (insert):
  - in_tready = 0.
  - On each free-slot cycle, load out_tdata = tid_reg slice[hdr_cnt], out_tlast = 0, then hdr_cnt++.
  - After slice HDR_BEATS-1 loads, go to S_BODY.
- S_STRIP:
  - in_tready = 1, independent of the output.
  - Each accepted beat is written into header slice[hdr_cnt], then hdr_cnt++.
  - If in_tlast arrives on any header beat: discard the packet, pulse err_runt the next cycle, return to S_START.
  - After HDR_BEATS beats: out_tid <= assembled header, go to S_BODY.
- S_BODY:
  - in_tready = slot free.
  - Each accepted beat loads out_tdata/out_tlast directly, giving one beat per cycle at full throughput.
  - An accepted beat with in_tlast returns to S_START.
  - out_tid stays stable from the first to the last body beat of a stripped packet. It is cleared at S_START when cur_mode is not strip.
- Insert of a 1-beat packet: HDR_BEATS header beats, then the data beat with tlast=1.
- A mode change mid-packet is ignored until the next S_START.
- Backpressure: no beat is dropped or duplicated while out_tready is held low for any length of time. in_tid may change after S_START without effect.
- Latency: 1 cycle from input handshake to out_tvalid in S_BODY. First header beat appears 2 cycles after in_tvalid rises at S_START.
- Reset asserted mid-packet: all state clears immediately. The remainder of the in-flight packet is treated as a new packet; upstream is responsible for flushing on reset.

Decomposition:
- Shared package stream_pkg holds:
  - mode encodings MODE_PASS/MODE_INSERT/MODE_STRIP;
  - state encodings S_START/S_HDR/S_STRIP/S_BODY;
  - a clog2 function for sizing hdr_cnt.
- No sub-module is needed; the output register is inline. The existing skid buffer may be placed downstream by the integrator.

Test Plan (DATA_WIDTH=8, HDR_BEATS=2 unless noted):
- Insert, in_tid=16'hBEEF, packet {01,02,03} with out_tready=1 → out {EF,BE,01,02,03}, tlast only on 03; in_tready low for 3 cycles at start.
- Strip, packet {AA,55,10,20} → out {10,20}, out_tid=16'h55AA on both beats, tlast on 20, err_runt=0.
- Strip runt {AA,55(tlast)} → no output beats, err_runt pulses once, and the next packet {01,02,03,04} strips normally to {03,04}.
- Pass, back-to-back 4-beat packets with random out_tready (~50%) → output byte-identical, no loss or duplication; mode switched to insert during the first packet takes effect only on the second.
- Insert of 1-beat packet {77} with HDR_BEATS=3, in_tid=24'h030201 → {01,02,03,77}, tlast on 77 only.
- areset pulsed during S_HDR after one header beat → outputs 0 asynchronously; after release, a fresh packet yields a complete header.
